product_accumulator: RTL and testbench
======================================

# product_accumulator

Accumulates the truncated products emitted by the registered 8-bit multiplier stage over a programmable run of `len` products. It delivers the sum through a valid/ready output handshake. It sits directly downstream of the multiplier and turns its per-cycle product stream into dot-product results for the consumer stage.

## Interface
- `BIT_SZ`, 8: width of each incoming product (matches the multiplier's `y`).
- `ACC_SZ`, 16: accumulator and result width; must be ≥ `BIT_SZ`.
- `LEN_W`, 8: width of the run-length field.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_l`  in  1  reset: asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  `LEN_W`  number of products in the run; captured when `start` is accepted.
- `sat_en`  in  1  1 = saturate at max, 0 = wrap modulo 2^`ACC_SZ`; captured with `start`.
- `in_valid`  in  1  `in_data` carries a product this cycle. Upstream drives it as its operand-issue valid delayed one cycle, aligned with the multiplier's registered output.
- `in_data`  in  `BIT_SZ`  product, unsigned.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_valid`  out  1  result available.
- `out_data`  out  `ACC_SZ`  accumulated sum.
- `overflow`  out  1  sum exceeded 2^`ACC_SZ`−1 during the current or last run.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky: `in_valid` seen outside ACC.

## Operation
- FSM states are IDLE, ACC and DONE.
- **IDLE:**
  - `start`=1 captures `len` and `sat_en`, and clears the accumulator, `overflow` and `err`.
  - If `len`≠0, go to ACC with remaining=`len`.
  - If `len`=0, go to DONE with sum 0.
- **ACC:**
  - Each cycle with `in_valid`=1 adds zero-extended `in_data` to acc and decrements remaining.
  - On the cycle remaining reaches 0, go to DONE.
  - Cycles without `in_valid` hold all state; gaps of any length are legal.
- **DONE:**
  - `out_valid`=1 and `out_data`=acc, both held stable until `out_ready`=1.
  - Handshake cycle (`out_valid` & `out_ready`) → IDLE.
- **Arithmetic:**
  - The sum is computed at `ACC_SZ`+1 bits; the carry-out sets `overflow` (sticky for the run).
  - With `sat_en`=1, acc clamps to 2^`ACC_SZ`−1 and stays there for the rest of the run.
  - With `sat_en`=0, acc keeps the low `ACC_SZ` bits.
- **Ignored inputs:**
  - `start` in ACC or DONE is ignored, including in the DONE handshake cycle; a new start is accepted the cycle after returning to IDLE.
  - `in_valid` in IDLE or DONE is dropped and sets `err`.
  - `len`/`sat_en` changes after capture have no effect.
- **Reset values:** `out_valid`=0, `out_data`=0, `overflow`=0, `busy`=0, `err`=0, acc=0, remaining=0, state=IDLE.
- **Reset mid-run:** asserting `rst_l` low in any state discards the partial sum immediately, asynchronously.

## Timing
- **Start:** `start` sampled at edge N in IDLE → `busy`=1 from N.
- **First product:** products are accepted from edge N+1.
- **Result latency:** last product sampled at edge M → `out_valid`=1 after edge M. The minimum start-to-result time for `len`=k with no gaps is k+1 cycles.
- **`len`=0:** `out_valid`=1 the cycle after the `start` edge.
- **Release:** `out_valid` drops and `busy` drops on the edge after the handshake cycle.
- **Throughput:** one product per cycle. The run-to-run gap is at least 2 cycles (DONE handshake, then IDLE start).
- **Outputs:** all outputs are registered or decoded directly from state registers; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic run:** `start` with `len`=3, then products 10, 20, 30 back-to-back, `out_ready`=1 → `out_valid` pulses for exactly 1 cycle, 1 cycle after the third product; `out_data`=60, `overflow`=0, `err`=0.
- **Gaps and backpressure:** `len`=4, products 1, 2, 3, 4 with 2-cycle gaps, `out_ready` held low for 5 cycles → `out_data`=10, and `out_valid`/`out_data` stay stable until `out_ready` rises; `busy` drops the cycle after the handshake.
- **Zero length:** `len`=0 → `out_valid`=1 the next cycle with `out_data`=0, and no products are consumed.
- **Saturate and wrap (`ACC_SZ`=10):** `len`=5 with five products of 255.
  - `sat_en`=1 → `out_data`=1023, `overflow`=1.
  - `sat_en`=0 → `out_data`=251, `overflow`=1.
- **Protocol errors:**
  - `in_valid`=1 in IDLE → `err`=1.
  - A following `start` clears `err`.
  - `start` pulsed during ACC → ignored; the sum is unaffected.
- **Reset mid-run:** `len`=8, `rst_l` low after 3 products → all outputs 0 and state IDLE immediately. A new run with `len`=2 and products 5, 6 → 11.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake and data bundle between the multiplier stage, the product
// accumulator and the downstream consumer.
interface product_accumulator_if #(
    parameter int BIT_SZ = 8,
    parameter int ACC_SZ = 16,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              sat_en;
    logic              in_valid;
    logic [BIT_SZ-1:0] in_data;
    logic              out_ready;
    logic              out_valid;
    logic [ACC_SZ-1:0] out_data;
    logic              overflow;
    logic              busy;
    logic              err;

    // Producer / consumer side
    modport master (
        output start, len, sat_en, in_valid, in_data, out_ready,
        input  out_valid, out_data, overflow, busy, err
    );

    // Accumulator side
    modport slave (
        input  start, len, sat_en, in_valid, in_data, out_ready,
        output out_valid, out_data, overflow, busy, err
    );
endinterface

// File: rtl/product_accumulator.sv
// Product accumulator: sums a programmable run of unsigned products from the
// registered multiplier stage and hands the total to the consumer through a
// valid/ready handshake. Optional saturation, sticky overflow and protocol
// error flags. All outputs come straight from registers.
module product_accumulator #(
    parameter int BIT_SZ = 8,
    parameter int ACC_SZ = 16,
    parameter int LEN_W  = 8
) (
    input logic                 clk,
    input logic                 rst_l,
    product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_SZ-1:0]  acc;
    logic [LEN_W-1:0]   remaining;
    logic               sat_mode;
    logic               out_valid_r;
    logic               busy_r;
    logic               overflow_r;
    logic               err_r;
    logic [ACC_SZ:0]    sum;

    // One bit wider than the accumulator so the carry-out is visible.
    function automatic logic [ACC_SZ:0] add_ext(input logic [ACC_SZ-1:0] a,
                                                input logic [BIT_SZ-1:0] d);
        return {1'b0, a} + (ACC_SZ+1)'(d);
    endfunction

    // Clamp to full scale on carry when saturating, otherwise keep low bits.
    function automatic logic [ACC_SZ-1:0] sat_or_wrap(input logic [ACC_SZ:0] s,
                                                      input logic sat);
        if (sat && s[ACC_SZ])
            return '1;
        return s[ACC_SZ-1:0];
    endfunction

    // Candidate sum for the product currently on the input.
    assign sum = add_ext(acc, bus.in_data);

    // Control FSM with registered result, status and error flags.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            acc         <= '0;
            remaining   <= '0;
            sat_mode    <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc        <= '0;
                        overflow_r <= 1'b0;
                        err_r      <= 1'b0;
                        sat_mode   <= bus.sat_en;
                        busy_r     <= 1'b1;
                        if (bus.len != '0) begin
                            remaining <= bus.len;
                            state     <= ACC;
                        end else begin
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    // A stray product in IDLE is dropped but flagged; the
                    // flag takes priority over the clear from a coincident start.
                    if (bus.in_valid)
                        err_r <= 1'b1;
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc       <= sat_or_wrap(sum, sat_mode);
                        remaining <= remaining - 1'b1;
                        if (sum[ACC_SZ])
                            overflow_r <= 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.in_valid)
                        err_r <= 1'b1;
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = acc;
    assign bus.overflow  = overflow_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator (ACC_SZ=10 so saturation and wrap are
// reachable with 8-bit products). Stimulus pushes the expected result of each
// run into a queue; a monitor pops it on every output handshake.
module tb_product_accumulator;

    localparam int BIT_SZ = 8;
    localparam int ACC_SZ = 10;
    localparam int LEN_W  = 8;
    localparam int MAXV   = (1 << ACC_SZ) - 1;

    typedef struct {
        logic [ACC_SZ-1:0] data;
        logic              ovf;
    } exp_t;

    logic clk;
    logic rst_l;
    int   checks;
    int   errors;

    exp_t              exp_q[$];
    logic [BIT_SZ-1:0] prods[$];

    product_accumulator_if #(.BIT_SZ(BIT_SZ), .ACC_SZ(ACC_SZ), .LEN_W(LEN_W)) bus ();

    product_accumulator #(.BIT_SZ(BIT_SZ), .ACC_SZ(ACC_SZ), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: running sum of the run's products with clamp or modulo on excess.
    task automatic model(input int n, input bit sat);
        int   total;
        bit   ovf;
        exp_t e;
        total = 0;
        ovf   = 1'b0;
        for (int i = 0; i < n; i++) begin
            total = total + int'(prods[i]);
            if (total > MAXV) begin
                ovf   = 1'b1;
                total = sat ? MAXV : total - (MAXV + 1);
            end
        end
        e.data = total[ACC_SZ-1:0];
        e.ovf  = ovf;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard compare on handshake, stability check under backpressure.
    logic              prev_valid;
    logic              prev_ready;
    logic [ACC_SZ-1:0] prev_data;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.out_valid && prev_valid && !prev_ready)
                check("data_stable", 32'(bus.out_data), 32'(prev_data));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", 32'(bus.out_data), 32'(e.data));
                    check("result_ovf", 32'(bus.overflow), 32'(e.ovf));
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // One run: gap<0 gives random gaps 0..3, bp = cycles of out_ready low,
    // exp_data>=0 adds a direct check of the result, poke pulses start in ACC.
    task automatic run(input int n, input bit sat, input int gap, input int bp,
                       input int exp_data, input bit poke);
        int g;
        model(n, sat);
        bus.out_ready = (bp == 0);
        bus.in_valid  = 1'b0;
        bus.start     = 1'b1;
        bus.len       = LEN_W'(n);
        bus.sat_en    = sat;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.len    = LEN_W'($urandom);
        bus.sat_en = 1'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_cleared", 32'(bus.err), 32'd0);
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                @(posedge clk); #1;
            end
            check("no_early_valid", 32'(bus.out_valid), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = prods[i];
            bus.start    = poke && (i == 1);
            bus.len      = LEN_W'(1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
        end
        check("valid_latency", 32'(bus.out_valid), 32'd1);
        if (exp_data >= 0)
            check("direct_data", 32'(bus.out_data), 32'(exp_data));
        if (bp > 0) begin
            repeat (bp) begin
                @(posedge clk); #1;
                check("held_valid", 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("busy_drop", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_l         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.sat_en    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // Basic run
        prods = '{8'd10, 8'd20, 8'd30};
        run(3, 1'b0, 0, 0, 60, 1'b0);
        check("basic_ovf", 32'(bus.overflow), 32'd0);
        check("basic_err", 32'(bus.err), 32'd0);

        // Gaps and backpressure
        prods = '{8'd1, 8'd2, 8'd3, 8'd4};
        run(4, 1'b0, 2, 5, 10, 1'b0);

        // Zero length
        prods = '{};
        run(0, 1'b0, 0, 0, 0, 1'b0);

        // Saturate, then wrap
        prods = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        run(5, 1'b1, 0, 0, 1023, 1'b0);
        check("sat_ovf", 32'(bus.overflow), 32'd1);
        run(5, 1'b0, 0, 1, 251, 1'b0);
        check("wrap_ovf", 32'(bus.overflow), 32'd1);

        // Stray product in IDLE, then cleared by the next start; start poked in ACC
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd77;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("err_set", 32'(bus.err), 32'd1);
        check("idle_drop", 32'(bus.busy), 32'd0);
        prods = '{8'd7, 8'd8, 8'd9};
        run(3, 1'b0, 1, 0, 24, 1'b1);

        // Reset mid-run
        bus.start  = 1'b1;
        bus.len    = LEN_W'(8);
        bus.sat_en = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd100;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_l = 1'b0;
        #1;
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        #2;
        rst_l = 1'b1;
        @(posedge clk); #1;
        prods = '{8'd5, 8'd6};
        run(2, 1'b0, 0, 0, 11, 1'b0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(0, 12));
            prods = '{};
            for (int i = 0; i < n; i++)
                prods.push_back(BIT_SZ'($urandom));
            run(n, 1'($urandom), -1, int'($urandom_range(0, 3)), -1, 1'($urandom));
        end

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
